rgb_matrix_scanner: RTL and testbench
=====================================

// Module: rgb_matrix_scanner
// PURPOSE
//  Downstream consumer of the JTAG user-chain outputs. Stores a 4-row x 30-bit RGB frame
//  written from the chain's red/blue/green column data and rgbRow one-hot row mask.
//  Time-multiplexes the frame onto the board RGB LED matrix: one row at a time, with
//  blanking between rows and 16-step PWM brightness.
//  Clocked by JTCK, so the display only advances while the host keeps TCK running
//  (TAP parked in Run-Test/Idle).
// PARAMETERS
//  DRIVE_CYCLES  256  cycles each row is driven; must be a multiple of 16, >= 16
//  BLANK_CYCLES  4    cycles all outputs inactive before each row; >= 1
//  ACTIVE_LOW    0    1 = column and row outputs inverted at the pins
// PORTS
//  JTCK        in   1   clock
//  JRSTN       in   1   asynchronous active-low reset
//  enable      in   1   1 = scanning; 0 = display off
//  brightness  in   4   PWM duty in 1/16 steps; 0 = off, 15 = 15/16
//  frame_load  in   1   single-cycle write strobe from the chain update
//  rgbRow      in   4   one-hot/multi-hot row write mask
//  red         in   10  column data to write
//  blue        in   10  column data to write
//  green       in   10  column data to write
//  red_o       out  10  red column drive
//  blue_o      out  10  blue column drive
//  green_o     out  10  green column drive
//  row_o       out  4   one-hot row drive
//  frame_sync  out  1   1-cycle pulse on the first DRIVE cycle of row 0
// BEHAVIOUR
//  - Reset (async, JRSTN=0):
//    - Frame buffer cleared; FSM = OFF; row index = 0; counters = 0.
//    - frame_sync = 0; all column and row outputs inactive (0, or 1 if ACTIVE_LOW).
//  - Outputs are registered and update on the same edge as the FSM, so they show the
//    new state in its first cycle.
//  - Frame write: on an edge with frame_load=1, every row i with rgbRow[i]=1 is written
//    with {green,blue,red}.
//    - rgbRow=0 writes nothing; multiple bits write all selected rows.
//    - Writes are accepted in every FSM state, including OFF.
//  - FSM states:
//    - OFF: outputs inactive. enable=1 -> BLANK, row 0, counter 0.
//    - BLANK: outputs inactive for BLANK_CYCLES cycles. Then -> DRIVE and latch
//      buffer[row] and brightness into shadow registers.
//    - DRIVE: lasts DRIVE_CYCLES cycles.
//      - row_o = one-hot(row).
//      - Columns = shadow data while counter[3:0] < shadow brightness, else inactive.
//      - After the last cycle: row = (row+1) mod 4, wraps 3 -> 0; -> BLANK.
//  - Tearing rules:
//    - The shadow latch takes the buffer value from before any same-edge write; that
//      write becomes visible on the row's next DRIVE.
//    - brightness changes during a row take effect on the next row.
//  - enable=0 in any state -> OFF on the next edge; outputs inactive that cycle. Re-enable
//    restarts at row 0 with BLANK.
//  - Frame period = 4 x (BLANK_CYCLES + DRIVE_CYCLES) = 1040 cycles at defaults.
//  - Reset mid-row forces the reset state immediately; no partial row completes.
// TESTING
//  - Reset with enable=1 held, then release:
//    - Outputs inactive for 4 cycles, then row_o=0001.
//    - frame_sync pulses once; row_o=0010 appears 260 cycles later.
//  - Write rgbRow=0100, red=0x3FF, others 0, brightness=15; observe row 2:
//    - red_o=0x3FF for 15 of every 16 cycles, 0 on counter[3:0]=15.
//    - Rows 0, 1, 3 stay dark.
//  - Write rgbRow=1111 with green=0x155 on the BLANK->DRIVE edge of row 1:
//    - Row 1 shows old data this pass and 0x155 on the next frame.
//    - Rows 2, 3, 0 show 0x155 this pass.
//  - brightness=0: no column is ever active. brightness=8: exactly 128 active cycles per
//    row.
//  - Deassert enable mid-DRIVE of row 3: all outputs inactive next cycle; re-enable ->
//    BLANK, then row 0.
//  - ACTIVE_LOW=1 build: after reset all outputs =1; a lit LED drives its column and row
//    bit to 0.

Source files
------------

// File: rtl/rgb_matrix_scanner.sv
// RGB LED matrix scanner: 4x30-bit frame buffer, row multiplexing with
// blanking and 16-step PWM, fed from the JTAG user-chain outputs.
module rgb_matrix_scanner #(
  parameter int DRIVE_CYCLES = 256,
  parameter int BLANK_CYCLES = 4,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic       JTCK,
  input  logic       JRSTN,
  input  logic       enable,
  input  logic [3:0] brightness,
  input  logic       frame_load,
  input  logic [3:0] rgbRow,
  input  logic [9:0] red,
  input  logic [9:0] blue,
  input  logic [9:0] green,
  output logic [9:0] red_o,
  output logic [9:0] blue_o,
  output logic [9:0] green_o,
  output logic [3:0] row_o,
  output logic       frame_sync
);

  localparam int CMAX =
    (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX);

  localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  localparam logic [9:0] COL_IDLE = {10{ACTIVE_LOW}};
  localparam logic [3:0] ROW_IDLE = {4{ACTIVE_LOW}};

  logic [3:0][29:0] fbuf;

  logic [1:0]    state, state_n;
  logic [1:0]    row, row_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [29:0]   sh_data, sh_data_n;
  logic [3:0]    sh_br, sh_br_n;

  logic [29:0] col_n;
  logic [3:0]  rdrv_n;
  logic        sync_n;

  // Next FSM state, shadow latch and the output image of that next state
  always_comb begin
    state_n   = state;
    row_n     = row;
    cnt_n     = cnt;
    sh_data_n = sh_data;
    sh_br_n   = sh_br;
    if (!enable) begin
      state_n = S_OFF;
      row_n   = 2'd0;
      cnt_n   = '0;
    end else begin
      case (state)
        S_OFF: begin
          state_n = S_BLANK;
          row_n   = 2'd0;
          cnt_n   = '0;
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n   = S_DRIVE;
            cnt_n     = '0;
            sh_data_n = fbuf[row];
            sh_br_n   = brightness;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        S_DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state_n = S_BLANK;
            row_n   = row + 2'd1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        default: begin
          state_n = S_OFF;
          row_n   = 2'd0;
          cnt_n   = '0;
        end
      endcase
    end

    col_n  = '0;
    rdrv_n = '0;
    sync_n = 1'b0;
    if (state_n == S_DRIVE) begin
      rdrv_n = 4'b0001 << row_n;
      if (cnt_n[3:0] < sh_br_n)
        col_n = sh_data_n;
      sync_n = (row_n == 2'd0) && (cnt_n == '0);
    end
  end

  // Scan state and registered pin drive
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      state      <= S_OFF;
      row        <= 2'd0;
      cnt        <= '0;
      sh_data    <= '0;
      sh_br      <= '0;
      red_o      <= COL_IDLE;
      blue_o     <= COL_IDLE;
      green_o    <= COL_IDLE;
      row_o      <= ROW_IDLE;
      frame_sync <= 1'b0;
    end else begin
      state      <= state_n;
      row        <= row_n;
      cnt        <= cnt_n;
      sh_data    <= sh_data_n;
      sh_br      <= sh_br_n;
      red_o      <= col_n[9:0]   ^ COL_IDLE;
      blue_o     <= col_n[19:10] ^ COL_IDLE;
      green_o    <= col_n[29:20] ^ COL_IDLE;
      row_o      <= rdrv_n       ^ ROW_IDLE;
      frame_sync <= sync_n;
    end
  end

  // Frame buffer writes from the chain, any state
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      fbuf <= '0;
    end else if (frame_load) begin
      for (int i = 0; i < 4; i++)
        if (rgbRow[i])
          fbuf[i] <= {green, blue, red};
    end
  end

endmodule

// File: tb/tb_rgb_matrix_scanner.sv
// Bench for rgb_matrix_scanner: per-row records checked against a
// queue of expected rows, plus directed latency and polarity checks.
module tb_rgb_matrix_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       enable, frame_load;
  logic [3:0] brightness, rgbRow;
  logic [9:0] red, blue, green;
  logic [9:0] red_o, blue_o, green_o;
  logic [3:0] row_o;
  logic       frame_sync;

  logic       al_en, al_load;
  logic [3:0] al_br, al_mask;
  logic [9:0] al_r_in, al_b_in, al_g_in;
  logic [9:0] al_red, al_blue, al_green;
  logic [3:0] al_row;
  logic       al_sync;

  rgb_matrix_scanner dut (
    .JTCK(clk), .JRSTN(rst_n), .enable(enable),
    .brightness(brightness), .frame_load(frame_load),
    .rgbRow(rgbRow), .red(red), .blue(blue), .green(green),
    .red_o(red_o), .blue_o(blue_o), .green_o(green_o),
    .row_o(row_o), .frame_sync(frame_sync)
  );

  rgb_matrix_scanner #(
    .DRIVE_CYCLES(16), .BLANK_CYCLES(1), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .JTCK(clk), .JRSTN(rst_n), .enable(al_en),
    .brightness(al_br), .frame_load(al_load),
    .rgbRow(al_mask), .red(al_r_in), .blue(al_b_in),
    .green(al_g_in), .red_o(al_red), .blue_o(al_blue),
    .green_o(al_green), .row_o(al_row), .frame_sync(al_sync)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] row;
    logic [9:0] r, g, b;
    int on, len, sync, gap;
    bit part;
  } rec_t;

  rec_t exp_q[$];

  task automatic push_row(input logic [3:0] rw, input logic [9:0] r,
                          input logic [9:0] g, input int on,
                          input int sync, input int gap,
                          input bit part = 1'b0);
    rec_t e;
    e.row = rw; e.r = r; e.g = g; e.b = '0;
    e.on = on; e.len = 256; e.sync = sync;
    e.gap = gap; e.part = part;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic check_rec(input rec_t a, input bit lk);
    rec_t e;
    bit bad;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL extra_row got row=%b", a.row);
      return;
    end
    e = exp_q.pop_front();
    bad = (a.row !== e.row) || lk || (e.gap >= 0 && a.gap != e.gap);
    if (!e.part)
      bad = bad || a.r !== e.r || a.g !== e.g || a.b !== e.b ||
            a.on != e.on || a.len != e.len || a.sync != e.sync;
    if (bad) begin
      errors++;
      $display("FAIL row_rec got row=%b r=%h g=%h b=%h on=%0d len=%0d sync=%0d gap=%0d leak=%0b exp row=%b r=%h g=%h b=%h on=%0d len=%0d sync=%0d gap=%0d",
               a.row, a.r, a.g, a.b, a.on, a.len, a.sync, a.gap, lk,
               e.row, e.r, e.g, e.b, e.on, e.len, e.sync, e.gap);
    end
  endtask

  // Monitor: fold each driven row into a record, compare when it ends
  rec_t cur;
  bit   in_row = 1'b0;
  bit   leak = 1'b0;
  int   gap = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_row = 1'b0;
      gap = 0;
      leak = 1'b0;
    end else if (row_o != 4'd0) begin
      if (!in_row) begin
        cur.row = row_o; cur.r = '0; cur.g = '0; cur.b = '0;
        cur.on = 0; cur.len = 0; cur.sync = 0;
        cur.gap = gap; cur.part = 1'b0;
        in_row = 1'b1;
      end
      cur.row = cur.row | row_o;
      cur.len++;
      if ((red_o | green_o | blue_o) != 10'd0) cur.on++;
      cur.r = cur.r | red_o;
      cur.g = cur.g | green_o;
      cur.b = cur.b | blue_o;
      cur.sync += int'(frame_sync);
    end else begin
      if (in_row) begin
        check_rec(cur, leak);
        in_row = 1'b0;
        gap = 0;
        leak = 1'b0;
      end
      gap++;
      if ((red_o | green_o | blue_o) != 10'd0 || frame_sync)
        leak = 1'b1;
    end
  end

  task automatic wait_sync();
    checks++;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (frame_sync) return;
    end
    errors++;
    $display("FAIL sync_timeout got=none exp=pulse");
  endtask

  // Active-low build: lit pixel pulls its column and row low
  initial begin
    al_en = 1'b0; al_load = 1'b0; al_br = 4'd15;
    al_mask = '0; al_r_in = '0; al_b_in = '0; al_g_in = '0;
    @(posedge rst_n);
    @(negedge clk);
    al_mask = 4'b0001; al_r_in = 10'h3FF; al_load = 1'b1;
    @(negedge clk);
    al_load = 1'b0; al_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (al_row != 4'hF) break;
    end
    chk("al_row", al_row, 4'b1110);
    chk("al_red_lit", al_red, 10'h000);
    chk("al_green_dark", al_green, 10'h3FF);
    chk("al_blue_dark", al_blue, 10'h3FF);
    chk("al_sync", al_sync, 1);
  end

  int n;

  initial begin
    enable = 1'b1; brightness = 4'd15; frame_load = 1'b0;
    rgbRow = '0; red = '0; blue = '0; green = '0;

    push_row(4'b0001, 10'h0,   10'h0,   0,   1, -1);
    push_row(4'b0010, 10'h0,   10'h0,   0,   0, 4);
    push_row(4'b0100, 10'h3FF, 10'h0,   240, 0, 4);
    push_row(4'b1000, 10'h0,   10'h0,   0,   0, 4);

    push_row(4'b0001, 10'h0,   10'h0,   0,   1, 4);
    push_row(4'b0010, 10'h0,   10'h0,   0,   0, 4);
    push_row(4'b0100, 10'h0,   10'h155, 240, 0, 4);
    push_row(4'b1000, 10'h0,   10'h155, 240, 0, 4);

    push_row(4'b0001, 10'h0,   10'h155, 240, 1, 4);
    push_row(4'b0010, 10'h0,   10'h155, 128, 0, 4);
    push_row(4'b0100, 10'h0,   10'h155, 128, 0, 4);
    push_row(4'b1000, 10'h0,   10'h155, 128, 0, 4);

    push_row(4'b0001, 10'h0,   10'h155, 128, 1, 4);
    push_row(4'b0010, 10'h0,   10'h0,   0,   0, 4);
    push_row(4'b0100, 10'h0,   10'h0,   0,   0, 4);
    push_row(4'b1000, 10'h0,   10'h0,   0,   0, 4);

    push_row(4'b0001, 10'h0,   10'h0,   0,   1, 4);
    push_row(4'b0010, 10'h0,   10'h155, 240, 0, 4);
    push_row(4'b0100, 10'h0,   10'h155, 240, 0, 4);
    push_row(4'b1000, 10'h0,   10'h0,   0,   0, 4, 1'b1);

    push_row(4'b0001, 10'h0,   10'h155, 240, 1, -1);
    push_row(4'b0010, 10'h0,   10'h155, 240, 0, 4);
    push_row(4'b0100, 10'h0,   10'h155, 240, 0, 4);
    push_row(4'b1000, 10'h0,   10'h155, 240, 0, 4);

    repeat (3) @(negedge clk);
    chk("rst_red", red_o, 0);
    chk("rst_green", green_o, 0);
    chk("rst_blue", blue_o, 0);
    chk("rst_row", row_o, 0);
    chk("rst_sync", frame_sync, 0);
    chk("al_rst_col", al_red & al_green & al_blue, 10'h3FF);
    chk("al_rst_row", al_row, 4'hF);
    chk("al_rst_sync", al_sync, 0);

    rst_n = 1'b1;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 2) begin
        rgbRow = 4'b0100; red = 10'h3FF; frame_load = 1'b1;
      end else begin
        frame_load = 1'b0;
      end
      if (row_o != 4'd0) break;
    end
    rgbRow = '0; red = '0;
    chk("first_row_lat", n, 5);
    chk("first_row", row_o, 4'b0001);
    chk("first_sync", frame_sync, 1);

    for (n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (row_o == 4'b0010) break;
    end
    chk("row1_lat", n, 260);

    wait_sync();
    repeat (259) @(posedge clk);
    @(negedge clk);
    rgbRow = 4'hF; green = 10'h155; frame_load = 1'b1;
    @(negedge clk);
    frame_load = 1'b0; green = '0; rgbRow = '0;
    chk("tear_edge_row", row_o, 4'b0010);

    wait_sync();
    brightness = 4'd8;
    wait_sync();
    brightness = 4'd0;
    wait_sync();
    brightness = 4'd15;

    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (row_o == 4'b1000) break;
    end
    repeat (100) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("off_row", row_o, 0);
    chk("off_cols", red_o | green_o | blue_o, 0);
    repeat (20) @(negedge clk);
    enable = 1'b1;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (row_o != 4'd0) break;
    end
    chk("reen_lat", n, 5);
    chk("reen_row", row_o, 4'b0001);

    for (n = 0; n < 3000 && exp_q.size() > 0; n++)
      @(negedge clk);
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0 rows pending", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
